dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, the number of 32-bit words in the shared data memory.
REQ-002 SHALL have parameter RR_EN, default 1, where 1 selects round-robin arbitration and 0 selects fixed priority with port 0 winning.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have ports req0_i / req1_i, input, 1, request valid for port 0 (CPU MEM stage) and port 1 (loader/debug).
REQ-006 SHALL have ports we0_i / we1_i, input, 1, request is a write.
REQ-007 SHALL have ports addr0_i / addr1_i, input, 32, byte address.
REQ-008 SHALL have ports wdata0_i / wdata1_i, input, 32, write data.
REQ-009 SHALL have ports ack0_o / ack1_o, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have ports err0_o / err1_o, output, 1, access rejected; valid only while the matching ack is high.
REQ-011 SHALL have port rdata_o, output, 32, read data; valid only while an ack is high.
REQ-012 SHALL have port mem_addr_o, output, 32, memory byte address.
REQ-013 SHALL have port mem_we_o, output, 1, memory write enable.
REQ-014 SHALL have port mem_wdata_o, output, 32, memory write data.
REQ-015 SHALL have port mem_rdata_i, input, 32, combinational memory read data.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-017 IDLE: if any req is high, SHALL pick a winner, latch its we/addr/wdata and winner id, and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-018 Arbitration with RR_EN=1: on a single request, SHALL grant it; on simultaneous requests, SHALL grant the port opposite to last_gnt.
REQ-019 Arbitration with RR_EN=0: SHALL grant port 0 whenever req0_i is high.
REQ-020 ACCESS (exactly one cycle): SHALL drive mem_addr_o, mem_wdata_o and mem_we_o from the latched request, capture mem_rdata_i into the rdata register, then go to RESP.
REQ-021 mem_we_o SHALL be high only in ACCESS, for a latched, valid write; it SHALL be registered and glitch-free, and 0 in every other state.
REQ-022 mem_addr_o and mem_wdata_o SHALL hold their latched values between transactions and SHALL NOT follow the req inputs.
REQ-023 RESP: SHALL pulse ack of the winner for one cycle, present rdata_o (0 for writes), update last_gnt to the winner, and go to IDLE.
REQ-024 Latency SHALL be: request sampled in IDLE at cycle N, ack at cycle N+2; peak throughput one access per 3 cycles.
REQ-025 A request is invalid if addr[1:0]!=0 or addr>>2 >= DEPTH_WORDS.
REQ-026 For an invalid request, the block SHALL keep mem_we_o at 0, set rdata_o to 0, and raise err with ack.
REQ-027 A requester SHALL hold req and payload until its ack; deassertion after latch SHALL NOT abort the transaction.
REQ-028 A req held high through its own ack SHALL be treated as a new request in the next IDLE.
REQ-029 The non-winning request SHALL remain pending and SHALL be served next under RR_EN=1.
REQ-030 ack0_o and ack1_o SHALL never both be high.
REQ-031 The block SHALL emit no ack without a prior latched request.

Reset
REQ-032 When rst_i is low, the block SHALL immediately set: state IDLE, last_gnt=1 (so port 0 wins first), latched request and rdata to 0, all outputs 0.
REQ-033 A reset asserted mid-ACCESS SHALL drop mem_we_o at once, lose the transaction and emit no ack.
REQ-034 After reset release, the block SHALL accept a request on the first rising edge.

Structure
REQ-035 A shared package SHALL hold the FSM state typedef (IDLE/ACCESS/RESP), the port-id constants, and the address-check helper constants (word shift 2).
REQ-036 One sub-module SHALL be used: dmem_rr_pick, combinational, taking req0, req1, last_gnt and RR_EN and returning the winner id.
REQ-037 The block SHALL contain no memory array; it SHALL connect to the existing data memory through the mem_* ports.

Verification
REQ-038 Scenario: reset, then port 0 write addr 0x10 data 0xDEADBEEF -> mem_we_o high in one cycle only with addr 0x10; ack0 two cycles after the request is sampled; err0=0.
REQ-039 Scenario: port 1 read 0x10 after that write -> ack1 with rdata_o=0xDEADBEEF; rdata_o=0 outside ack.
REQ-040 Scenario: both ports request continuously with RR_EN=1 -> grants alternate 0,1,0,1; with RR_EN=0 -> port 0 only, port 1 starved.
REQ-041 Scenario: write to addr 0x13, then write to 0x1000 with DEPTH_WORDS=1024 -> ack with err; mem_we_o stays 0; memory contents unchanged.
REQ-042 Scenario: rst_i pulsed low during ACCESS of a write -> mem_we_o falls asynchronously; no ack; the next request after release is granted to port 0.
REQ-043 Scenario: req0 dropped one cycle after being sampled -> transaction still completes with ack0 at N+2; no second ack.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter:
//   arb_state_e  - arbiter FSM state (IDLE / ACCESS / RESP)
//   PORT0/PORT1  - requester ids (0 = CPU MEM stage, 1 = loader/debug)
//   WORD_SHIFT   - byte-address to word-index shift
//   addr_valid() - alignment and range check of a byte address
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int unsigned WORD_SHIFT = 2;

    // A byte address is usable only if it is word aligned and its word
    // index falls inside the memory.
    function automatic logic addr_valid(input logic [31:0] addr,
                                        input logic [31:0] depth_words);
        return (addr[1:0] == 2'b00) && ((addr >> WORD_SHIFT) < depth_words);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the two requester ports and the memory-side bus of the arbiter.
//   req*/we*/addr*/wdata*  : requester -> arbiter
//   ack*/err*/rdata_o      : arbiter -> requester
//   mem_addr_o/mem_we_o/mem_wdata_o : arbiter -> data memory
//   mem_rdata_i            : data memory -> arbiter (combinational read)
//
// Handshake: a requester raises reqN_i with a stable payload and keeps both
// until it sees ackN_o (a single-cycle pulse). errN_o and rdata_o are only
// meaningful in the cycle ackN_o is high. A req still high in the cycle after
// its ack is a new request.
interface dmem_arbiter_if;
    logic        req0_i;
    logic        req1_i;
    logic        we0_i;
    logic        we1_i;
    logic [31:0] addr0_i;
    logic [31:0] addr1_i;
    logic [31:0] wdata0_i;
    logic [31:0] wdata1_i;
    logic        ack0_o;
    logic        ack1_o;
    logic        err0_o;
    logic        err1_o;
    logic [31:0] rdata_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    // Arbiter side.
    modport slave (
        input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i,
               wdata0_i, wdata1_i, mem_rdata_i,
        output ack0_o, ack1_o, err0_o, err1_o, rdata_o,
               mem_addr_o, mem_we_o, mem_wdata_o
    );

    // Requesters plus memory, seen from outside the arbiter.
    modport master (
        output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i,
               wdata0_i, wdata1_i, mem_rdata_i,
        input  ack0_o, ack1_o, err0_o, err1_o, rdata_o,
               mem_addr_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick
// Combinational winner selection for the two-port arbiter.
//   req0, req1 : pending requests
//   last_gnt   : id of the port served most recently
//   rr_en      : 1 = round-robin, 0 = fixed priority (port 0 first)
//   gnt        : winning port id (only meaningful when a request is pending)
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    input  logic rr_en,
    output logic gnt
);

    always_comb begin
        gnt = PORT0;
        if (req0 && req1) begin
            // Contention: round-robin hands the grant to the port that was
            // not served last; fixed priority always favours port 0.
            gnt = rr_en ? ~last_gnt : PORT0;
        end else if (req1) begin
            gnt = PORT1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter in front of the shared data memory. Each transaction
// takes three cycles: IDLE (arbitrate and latch), ACCESS (drive the memory,
// capture read data), RESP (single-cycle ack to the winner).
//   clk_i, rst_i : clock, asynchronous active-low reset
//   bus          : requester ports and memory-side bus (dmem_arbiter_if)
//   state_o      : current FSM state, for observation
// Parameters:
//   DEPTH_WORDS  : number of 32-bit words in the memory
//   RR_EN        : 1 = round-robin, 0 = fixed priority with port 0 winning
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter bit          RR_EN       = 1'b1
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_arbiter_if.slave    bus,
    output arb_state_e       state_o
);

    localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

    arb_state_e  state_q;
    logic        last_gnt_q;
    logic        win_q;
    logic        lat_we_q;
    logic        lat_ok_q;
    logic [31:0] lat_addr_q;
    logic [31:0] lat_wdata_q;
    logic [31:0] rdata_q;
    logic        mem_we_q;
    logic        ack0_q;
    logic        ack1_q;
    logic        err0_q;
    logic        err1_q;

    logic        gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_ok;

    dmem_rr_pick u_pick (
        .req0     (bus.req0_i),
        .req1     (bus.req1_i),
        .last_gnt (last_gnt_q),
        .rr_en    (RR_EN),
        .gnt      (gnt)
    );

    // Payload of the port that would win this cycle.
    always_comb begin
        sel_we    = (gnt == PORT1) ? bus.we1_i    : bus.we0_i;
        sel_addr  = (gnt == PORT1) ? bus.addr1_i  : bus.addr0_i;
        sel_wdata = (gnt == PORT1) ? bus.wdata1_i : bus.wdata0_i;
        sel_ok    = addr_valid(sel_addr, DEPTH);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= PORT1;       // port 0 wins the first contention
            win_q       <= PORT0;
            lat_we_q    <= 1'b0;
            lat_ok_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req0_i || bus.req1_i) begin
                        win_q       <= gnt;
                        lat_we_q    <= sel_we;
                        lat_ok_q    <= sel_ok;
                        lat_addr_q  <= sel_addr;
                        lat_wdata_q <= sel_wdata;
                        // Write strobe is set on entry so it is a clean
                        // registered pulse covering exactly the ACCESS cycle.
                        mem_we_q    <= sel_we && sel_ok;
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_we_q <= 1'b0;
                    rdata_q  <= (lat_ok_q && !lat_we_q) ? bus.mem_rdata_i : '0;
                    ack0_q   <= (win_q == PORT0);
                    ack1_q   <= (win_q == PORT1);
                    err0_q   <= (win_q == PORT0) && !lat_ok_q;
                    err1_q   <= (win_q == PORT1) && !lat_ok_q;
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    // rdata is cleared with the ack so it reads 0 between
                    // responses; the memory address/data keep their values.
                    ack0_q     <= 1'b0;
                    ack1_q     <= 1'b0;
                    err0_q     <= 1'b0;
                    err1_q     <= 1'b0;
                    rdata_q    <= '0;
                    last_gnt_q <= win_q;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    mem_we_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0_o      = ack0_q;
    assign bus.ack1_o      = ack1_q;
    assign bus.err0_o      = err0_q;
    assign bus.err1_o      = err1_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.mem_addr_o  = lat_addr_q;
    assign bus.mem_wdata_o = lat_wdata_q;
    assign bus.mem_we_o    = mem_we_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Bench for dmem_arbiter: a round-robin instance (main checks) and a
// fixed-priority instance (starvation check), each with its own memory.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int DEPTH = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if bus_rr();
    dmem_arbiter_if bus_fp();
    arb_state_e state_rr;
    arb_state_e state_fp;

    dmem_arbiter #(.DEPTH_WORDS(DEPTH), .RR_EN(1'b1)) u_rr (
        .clk_i(clk), .rst_i(rst_n), .bus(bus_rr), .state_o(state_rr));
    dmem_arbiter #(.DEPTH_WORDS(DEPTH), .RR_EN(1'b0)) u_fp (
        .clk_i(clk), .rst_i(rst_n), .bus(bus_fp), .state_o(state_fp));

    // ---------------- memories ----------------
    logic [31:0] mem_rr [0:DEPTH-1] = '{default: 32'h0};
    logic [31:0] mem_fp [0:DEPTH-1] = '{default: 32'h0};
    assign bus_rr.mem_rdata_i = mem_rr[bus_rr.mem_addr_o[11:2]];
    assign bus_fp.mem_rdata_i = mem_fp[bus_fp.mem_addr_o[11:2]];
    always @(posedge clk) begin
        if (bus_rr.mem_we_o) mem_rr[bus_rr.mem_addr_o[11:2]] <= bus_rr.mem_wdata_o;
        if (bus_fp.mem_we_o) mem_fp[bus_fp.mem_addr_o[11:2]] <= bus_fp.mem_wdata_o;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus monitor (round-robin instance, plus ack exclusivity on both).
    int rr_acks = 0;
    int rr_we_pulses = 0;
    int both_high = 0;
    int we_double = 0;
    logic we_prev = 1'b0;
    logic [31:0] last_we_addr = '0;
    always @(negedge clk) begin
        if (bus_rr.ack0_o) rr_acks++;
        if (bus_rr.ack1_o) rr_acks++;
        if (bus_rr.ack0_o && bus_rr.ack1_o) both_high++;
        if (bus_fp.ack0_o && bus_fp.ack1_o) both_high++;
        if (bus_rr.mem_we_o) begin
            rr_we_pulses++;
            last_we_addr = bus_rr.mem_addr_o;
            if (we_prev) we_double++;
        end
        we_prev = bus_rr.mem_we_o;
    end

    // ---------------- reference model ----------------
    // Transaction-level: a word array, the last served port, and counts of
    // expected acks and memory write strobes.
    logic [31:0] ref_mem [0:DEPTH-1] = '{default: 32'h0};
    logic model_last = 1'b1;
    int exp_acks = 0;
    int exp_we = 0;
    logic [33:0] exp_q[$];   // {port, err, rdata}

    function automatic logic [33:0] model_apply(input logic p, input logic we,
                                                input logic [31:0] addr, input logic [31:0] wdata);
        logic ok;
        logic [31:0] rd;
        ok = (addr % 4 == 0) && (addr / 4 < DEPTH);
        rd = '0;
        if (ok && we) begin
            ref_mem[addr[11:2]] = wdata;
            exp_we++;
        end
        if (ok && !we) rd = ref_mem[addr[11:2]];
        exp_acks++;
        model_last = p;
        return {p, ~ok, rd};
    endfunction

    // ---------------- drivers ----------------
    task automatic set_port(input logic p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 1'b0) begin
            bus_rr.req0_i = req; bus_rr.we0_i = we; bus_rr.addr0_i = addr; bus_rr.wdata0_i = wdata;
        end else begin
            bus_rr.req1_i = req; bus_rr.we1_i = we; bus_rr.addr1_i = addr; bus_rr.wdata1_i = wdata;
        end
    endtask

    // Single request from IDLE; latency counted in falling edges after the
    // request is raised (ack expected on the second).
    task automatic run_txn(input logic p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int lat, output logic err,
                           output logic [31:0] rd, output logic other_ack);
        lat = 0; err = 1'b0; rd = '0; other_ack = 1'b0;
        @(negedge clk);
        set_port(p, 1'b1, we, addr, wdata);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if ((p == 1'b0) ? bus_rr.ack1_o : bus_rr.ack0_o) other_ack = 1'b1;
            if ((p == 1'b0) ? bus_rr.ack0_o : bus_rr.ack1_o) begin
                lat = i;
                err = (p == 1'b0) ? bus_rr.err0_o : bus_rr.err1_o;
                rd  = bus_rr.rdata_o;
                break;
            end
        end
        set_port(p, 1'b0, we, addr, wdata);
    endtask

    // One round of up to two concurrent requests, each held until its ack.
    // Expected responses come from the model in the order it predicts.
    task automatic run_round(input logic use0, input logic use1,
                             input logic we0, input logic we1,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             output logic first_port);
        logic pend0, pend1, first_seen, got_p, got_err;
        logic [33:0] e;
        @(negedge clk);
        if (use0 && use1) begin
            if (model_last == 1'b1) begin
                exp_q.push_back(model_apply(1'b0, we0, a0, d0));
                exp_q.push_back(model_apply(1'b1, we1, a1, d1));
            end else begin
                exp_q.push_back(model_apply(1'b1, we1, a1, d1));
                exp_q.push_back(model_apply(1'b0, we0, a0, d0));
            end
        end else if (use0) begin
            exp_q.push_back(model_apply(1'b0, we0, a0, d0));
        end else if (use1) begin
            exp_q.push_back(model_apply(1'b1, we1, a1, d1));
        end
        set_port(1'b0, use0, we0, a0, d0);
        set_port(1'b1, use1, we1, a1, d1);
        pend0 = use0; pend1 = use1; first_seen = 1'b0; first_port = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!(pend0 || pend1)) break;
            @(negedge clk);
            if (bus_rr.ack0_o || bus_rr.ack1_o) begin
                got_p   = bus_rr.ack1_o;
                got_err = got_p ? bus_rr.err1_o : bus_rr.err0_o;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_port = got_p;
                    chk("round_first_latency", i, 2);
                end
                if (exp_q.size() == 0) begin
                    chk("round_unexpected_ack", {got_p, got_err, bus_rr.rdata_o}, 34'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("round_ack", {got_p, got_err, bus_rr.rdata_o}, e);
                end
                if (got_p == 1'b0) begin pend0 = 1'b0; set_port(1'b0, 1'b0, we0, a0, d0); end
                else               begin pend1 = 1'b0; set_port(1'b1, 1'b0, we1, a1, d1); end
            end
        end
        if (pend0 || pend1) begin
            chk("round_timeout", {pend0, pend1}, 0);
            set_port(1'b0, 1'b0, we0, a0, d0);
            set_port(1'b1, 1'b0, we1, a1, d1);
            exp_q.delete();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k == 0) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        if (k == 1) return 32'($urandom_range(DEPTH, 4 * DEPTH)) << 2;
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    // ---------------- vectors ----------------
    typedef struct {
        logic        p;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt, n, last_i, we_before;
        logic err, other, first, gp, exp_first;
        logic [31:0] rd;
        logic [33:0] e;

        vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h13,   32'h11111111, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h1000, 32'h22222222, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,    32'h0,        1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 32'hFFC,  32'h12345678, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 32'hFFC,  32'h0,        1'b0, 32'h12345678};
        vecs[8]  = '{1'b1, 1'b0, 32'h1000, 32'h0,        1'b1, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h2,    32'h0,        1'b1, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h0,    32'hA5A5A5A5, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,    32'h0,        1'b0, 32'hA5A5A5A5};

        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        bus_fp.req0_i = 1'b0; bus_fp.we0_i = 1'b0; bus_fp.addr0_i = '0; bus_fp.wdata0_i = '0;
        bus_fp.req1_i = 1'b0; bus_fp.we1_i = 1'b0; bus_fp.addr1_i = '0; bus_fp.wdata1_i = '0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("reset_state", state_rr, ST_IDLE);
        chk("reset_acks", {bus_rr.ack0_o, bus_rr.ack1_o, bus_rr.err0_o, bus_rr.err1_o}, 0);
        chk("reset_rdata", bus_rr.rdata_o, 0);
        chk("reset_mem_we", bus_rr.mem_we_o, 0);
        chk("reset_mem_addr", bus_rr.mem_addr_o, 0);
        chk("reset_mem_wdata", bus_rr.mem_wdata_o, 0);
        rst_n = 1'b1;

        // ---- table-driven single transactions ----
        for (int k = 0; k < 12; k++) begin
            we_before = rr_we_pulses;
            void'(model_apply(vecs[k].p, vecs[k].we, vecs[k].addr, vecs[k].wdata));
            run_txn(vecs[k].p, vecs[k].we, vecs[k].addr, vecs[k].wdata, lat, err, rd, other);
            chk($sformatf("vec%0d_latency", k), lat, 2);
            chk($sformatf("vec%0d_err", k), err, vecs[k].exp_err);
            chk($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
            chk($sformatf("vec%0d_other_ack", k), other, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_ack_after", k), {bus_rr.ack0_o, bus_rr.ack1_o}, 0);
            chk($sformatf("vec%0d_rdata_after", k), bus_rr.rdata_o, 0);
            chk($sformatf("vec%0d_we_pulses", k), rr_we_pulses - we_before,
                (vecs[k].we && !vecs[k].exp_err) ? 1 : 0);
            if (vecs[k].we && !vecs[k].exp_err)
                chk($sformatf("vec%0d_we_addr", k), last_we_addr, vecs[k].addr);
        end

        // ---- req0 dropped one cycle after being sampled ----
        @(negedge clk);
        e = model_apply(1'b0, 1'b0, 32'h10, 32'h0);
        set_port(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        set_port(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        cnt = 0; lat = 0; rd = '0;
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            if (bus_rr.ack0_o) begin
                cnt++;
                if (lat == 0) begin lat = i; rd = bus_rr.rdata_o; end
            end
        end
        chk("drop_latency", lat, 2);
        chk("drop_ack_count", cnt, 1);
        chk("drop_rdata", rd, e[31:0]);

        // ---- continuous contention, round-robin ----
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b0, 32'h10, '0);
        set_port(1'b1, 1'b1, 1'b0, 32'hFFC, '0);
        exp_first = ~model_last;
        n = 0; last_i = 0;
        for (int i = 1; i <= 40; i++) begin
            if (n >= 6) break;
            @(negedge clk);
            if (bus_rr.ack0_o || bus_rr.ack1_o) begin
                gp = bus_rr.ack1_o;
                chk($sformatf("rr_grant%0d", n), gp, exp_first ^ n[0]);
                if (n > 0) chk($sformatf("rr_gap%0d", n), i - last_i, 3);
                e = model_apply(gp, 1'b0, gp ? 32'hFFC : 32'h10, '0);
                chk($sformatf("rr_rdata%0d", n), bus_rr.rdata_o, e[31:0]);
                last_i = i;
                n++;
                if (n == 6) begin
                    set_port(1'b0, 1'b0, 1'b0, 32'h10, '0);
                    set_port(1'b1, 1'b0, 1'b0, 32'hFFC, '0);
                end
            end
        end
        chk("rr_ack_count", n, 6);

        // ---- continuous contention, fixed priority ----
        @(negedge clk);
        bus_fp.req0_i = 1'b1; bus_fp.req1_i = 1'b1;
        cnt = 0; n = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (bus_fp.ack0_o) cnt++;
            if (bus_fp.ack1_o) n++;
        end
        bus_fp.req0_i = 1'b0; bus_fp.req1_i = 1'b0;
        chk("fp_port0_acks", cnt, 5);
        chk("fp_port1_starved", n, 0);

        // ---- reset during ACCESS of a write ----
        @(negedge clk);
        set_port(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        chk("rst_we_in_access", bus_rr.mem_we_o, 1);
        exp_we++;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we_async_drop", bus_rr.mem_we_o, 0);
        chk("rst_state_async", state_rr, ST_IDLE);
        set_port(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_rr.ack0_o || bus_rr.ack1_o) cnt++;
        end
        chk("rst_no_ack", cnt, 0);
        chk("rst_mem_untouched", mem_rr[8], ref_mem[8]);
        run_round(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'hFFC, '0, '0, first);
        chk("rst_first_grant_port0", first, 0);

        // ---- randomized rounds against the model ----
        for (int r = 0; r < 40; r++) begin
            int unsigned mode;
            mode = $urandom_range(0, 2);
            run_round(mode != 1, mode != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      rand_addr(), rand_addr(), $urandom(), $urandom(), first);
        end

        // ---- end-of-run bus totals ----
        repeat (3) @(negedge clk);
        chk("ack_exclusive", both_high, 0);
        chk("ack_total", rr_acks, exp_acks);
        chk("we_pulse_total", rr_we_pulses, exp_we);
        chk("we_single_cycle", we_double, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
